// File: rtl/gate_bist_sequencer.sv
// Built-in self test for the two-input gate block. Walks a/b through 00..11,
// lets the block settle, and compares its eight outputs against golden values.
module gate_bist_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int LOOPS         = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       a_out,
    output logic       b_out,
    input  logic [7:0] gate_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] fail_mask,
    output logic [7:0] err_count,
    output logic [1:0] first_fail_vec,
    output logic       first_fail_vld
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_CHECK  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0] state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [1:0] ab_q, ab_d;
    logic [7:0] loop_q, loop_d;
    logic [3:0] cnt_q, cnt_d;
    logic       done_q, done_d;
    logic [7:0] fmask_q, fmask_d;
    logic [7:0] err_q, err_d;
    logic [1:0] ffv_q, ffv_d;
    logic       ffvld_q, ffvld_d;
    logic [7:0] miss;

    // Expected {xnor,xor,nor,nand,not_b,not_a,or,and} for each {a,b}.
    function automatic logic [7:0] golden(input logic [1:0] v);
        case (v)
            2'd0:    golden = 8'hBC;
            2'd1:    golden = 8'h56;
            2'd2:    golden = 8'h5A;
            default: golden = 8'h83;
        endcase
    endfunction

    assign miss = gate_in ^ golden(vec_q);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        ab_d    = ab_q;
        loop_d  = loop_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        fmask_d = fmask_q;
        err_d   = err_q;
        ffv_d   = ffv_q;
        ffvld_d = ffvld_q;
        // Abort wins over everything; partial results stay visible.
        if (abort) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            ab_d    = 2'd0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d = S_SETTLE;
                        vec_d   = 2'd0;
                        ab_d    = 2'd0;
                        loop_d  = 8'd0;
                        cnt_d   = 4'd0;
                        done_d  = 1'b0;
                        fmask_d = 8'd0;
                        err_d   = 8'd0;
                        ffv_d   = 2'd0;
                        ffvld_d = 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == 4'(SETTLE_CYCLES - 1)) state_d = S_CHECK;
                    else                                cnt_d   = cnt_q + 4'd1;
                end
                default: begin
                    if (miss != 8'd0) begin
                        fmask_d = fmask_q | miss;
                        if (err_q != 8'hFF) err_d = err_q + 8'd1;
                        if (!ffvld_q) begin
                            ffv_d   = vec_q;
                            ffvld_d = 1'b1;
                        end
                    end
                    if (vec_q == 2'd3 && loop_q == 8'(LOOPS - 1)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        ab_d    = 2'd0;
                    end else begin
                        state_d = S_SETTLE;
                        vec_d   = vec_q + 2'd1;
                        ab_d    = vec_q + 2'd1;
                        cnt_d   = 4'd0;
                        if (vec_q == 2'd3) loop_d = loop_q + 8'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            vec_q   <= 2'd0;
            ab_q    <= 2'd0;
            loop_q  <= 8'd0;
            cnt_q   <= 4'd0;
            done_q  <= 1'b0;
            fmask_q <= 8'd0;
            err_q   <= 8'd0;
            ffv_q   <= 2'd0;
            ffvld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            ab_q    <= ab_d;
            loop_q  <= loop_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            fmask_q <= fmask_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffvld_q <= ffvld_d;
        end
    end

    assign a_out          = ab_q[1];
    assign b_out          = ab_q[0];
    assign busy           = (state_q == S_SETTLE) || (state_q == S_CHECK);
    assign done           = done_q;
    assign pass           = done_q & (fmask_q == 8'd0);
    assign fail_mask      = fmask_q;
    assign err_count      = err_q;
    assign first_fail_vec = ffv_q;
    assign first_fail_vld = ffvld_q;

endmodule

// File: tb/tb_gate_bist_sequencer.sv
// Bench for gate_bist_sequencer: a table of fault patterns, random fault
// patterns against a schedule-based model, and abort/restart/reset sequences.
module tb_gate_bist_sequencer;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       start_s = '0;
    logic [2:0]       abort_s = '0;
    logic [2:0][7:0]  gate_s = '0;
    logic [2:0]       a_s, b_s, busy_s, done_s, pass_s, ffvld_s;
    logic [2:0][7:0]  fm_s, err_s;
    logic [2:0][1:0]  ffv_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gate_bist_sequencer #(.SETTLE_CYCLES(2), .LOOPS(1)) u_d0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .abort(abort_s[0]),
        .a_out(a_s[0]), .b_out(b_s[0]), .gate_in(gate_s[0]), .busy(busy_s[0]),
        .done(done_s[0]), .pass(pass_s[0]), .fail_mask(fm_s[0]), .err_count(err_s[0]),
        .first_fail_vec(ffv_s[0]), .first_fail_vld(ffvld_s[0]));

    gate_bist_sequencer #(.SETTLE_CYCLES(2), .LOOPS(3)) u_d1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .abort(abort_s[1]),
        .a_out(a_s[1]), .b_out(b_s[1]), .gate_in(gate_s[1]), .busy(busy_s[1]),
        .done(done_s[1]), .pass(pass_s[1]), .fail_mask(fm_s[1]), .err_count(err_s[1]),
        .first_fail_vec(ffv_s[1]), .first_fail_vld(ffvld_s[1]));

    gate_bist_sequencer #(.SETTLE_CYCLES(1), .LOOPS(100)) u_d2 (
        .clk(clk), .rst(rst), .start(start_s[2]), .abort(abort_s[2]),
        .a_out(a_s[2]), .b_out(b_s[2]), .gate_in(gate_s[2]), .busy(busy_s[2]),
        .done(done_s[2]), .pass(pass_s[2]), .fail_mask(fm_s[2]), .err_count(err_s[2]),
        .first_fail_vec(ffv_s[2]), .first_fail_vld(ffvld_s[2]));

    typedef struct packed {
        logic [7:0] fm;
        logic [7:0] err;
        logic [1:0] ffv;
        logic       ffvld;
    } res_t;

    typedef struct {
        int              inst;
        int              loops;
        int              settle;
        logic [3:0][7:0] msk;   // msk[v] = bits flipped from golden at vector v
        res_t            exp;
    } vec_t;

    vec_t tbl[6];
    logic [7:0] gold [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Results after the first n CHECKs, straight from the rules.
    function automatic res_t model(input logic [3:0][7:0] msk, input int n);
        res_t r = '0;
        int   cnt = 0;
        for (int k = 0; k < n; k++) begin
            if (msk[k % 4] != 8'd0) begin
                r.fm |= msk[k % 4];
                cnt++;
                if (!r.ffvld) begin
                    r.ffv   = 2'(k % 4);
                    r.ffvld = 1'b1;
                end
            end
        end
        r.err = (cnt > 255) ? 8'd255 : 8'(cnt);
        return r;
    endfunction

    function automatic res_t got(input int idx);
        return '{fm_s[idx], err_s[idx], ffv_s[idx], ffvld_s[idx]};
    endfunction

    // Start pulse lands in cycle 0; everything is sampled/driven at negedge.
    task automatic run(input string tag, input int idx, input int loops, input int settle,
                       input logic [3:0][7:0] msk, input res_t exp,
                       input int restart_cyc, input int abort_cyc, input int rst_cyc);
        int ncheck = 4 * loops;
        int period = settle + 1;
        int tdone  = ncheck * period + 1;
        int last   = (abort_cyc >= 0) ? abort_cyc + 1 : (rst_cyc >= 0) ? rst_cyc : tdone;
        int nseen  = 0;
        @(negedge clk);
        start_s[idx] = 1'b1;
        gate_s[idx]  = 8'($urandom);
        for (int cyc = 1; cyc <= last; cyc++) begin
            @(negedge clk);
            start_s[idx] = (cyc == restart_cyc);
            abort_s[idx] = (cyc == abort_cyc);
            if (cyc == rst_cyc) begin
                rst = 1'b1;
                #1;
                chk({tag, " rst_zero"}, 32'({a_s[idx], b_s[idx], busy_s[idx], done_s[idx],
                    pass_s[idx], fm_s[idx], err_s[idx], ffv_s[idx], ffvld_s[idx]}), 32'd0);
                break;
            end
            if (cyc % period == 0 && cyc / period <= ncheck &&
                (abort_cyc < 0 || cyc < abort_cyc)) begin
                int v = (cyc / period - 1) % 4;
                gate_s[idx] = gold[v] ^ msk[v];
                nseen++;
                if (idx != 2 || cyc < 40) begin
                    chk($sformatf("%s ab@%0d", tag, cyc), 32'({a_s[idx], b_s[idx]}), 32'(v));
                    chk($sformatf("%s busy@%0d", tag, cyc), 32'({busy_s[idx], done_s[idx]}), 32'b10);
                end
            end else begin
                gate_s[idx] = 8'($urandom);
            end
            if (abort_cyc < 0 && rst_cyc < 0 && cyc == tdone - 1)
                chk({tag, " done_early"}, 32'(done_s[idx]), 32'd0);
            if (abort_cyc < 0 && rst_cyc < 0 && cyc == tdone) begin
                chk({tag, " done"}, 32'({done_s[idx], busy_s[idx], a_s[idx], b_s[idx]}), 32'b1000);
                chk({tag, " result"}, 32'(got(idx)), 32'(exp));
                chk({tag, " pass"}, 32'(pass_s[idx]), 32'(exp.fm == 8'd0));
            end
            if (abort_cyc >= 0 && cyc == abort_cyc + 1) begin
                chk({tag, " abort_idle"}, 32'({done_s[idx], pass_s[idx], busy_s[idx], a_s[idx], b_s[idx]}), 32'd0);
                chk({tag, " abort_partial"}, 32'(got(idx)), 32'(model(msk, nseen)));
            end
        end
        start_s[idx] = 1'b0;
        abort_s[idx] = 1'b0;
    endtask

    initial begin
        logic [3:0][7:0] rm;
        gold = '{8'hBC, 8'h56, 8'h5A, 8'h83};
        tbl[0] = '{0, 1,   2, {8'h00, 8'h00, 8'h00, 8'h00}, '{8'h00, 8'd0,   2'b00, 1'b0}};
        tbl[1] = '{0, 1,   2, {8'h00, 8'h40, 8'h40, 8'h00}, '{8'h40, 8'd2,   2'b01, 1'b1}};
        tbl[2] = '{0, 1,   2, {8'h81, 8'h00, 8'h00, 8'h00}, '{8'h81, 8'd1,   2'b11, 1'b1}};
        tbl[3] = '{0, 1,   2, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, '{8'hFF, 8'd4,   2'b00, 1'b1}};
        tbl[4] = '{1, 3,   2, {8'h00, 8'h01, 8'h01, 8'h01}, '{8'h01, 8'd9,   2'b00, 1'b1}};
        tbl[5] = '{2, 100, 1, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, '{8'hFF, 8'd255, 2'b00, 1'b1}};

        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("reset_state%0d", i), 32'({a_s[i], b_s[i], busy_s[i], done_s[i],
                pass_s[i], fm_s[i], err_s[i], ffv_s[i], ffvld_s[i]}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++)
            run($sformatf("tbl%0d", i), tbl[i].inst, tbl[i].loops, tbl[i].settle,
                tbl[i].msk, tbl[i].exp, -1, -1, -1);

        // Re-pulsed start while busy is ignored; done still in cycle 13.
        run("restart", 0, 1, 2, tbl[1].msk, tbl[1].exp, 5, -1, -1);
        // Abort in cycle 7 keeps partial results from the CHECKs at 3 and 6.
        run("abort", 0, 1, 2, tbl[1].msk, tbl[1].exp, 5, 7, -1);
        // Reset mid-run, then a clean run.
        run("rst_mid", 0, 1, 2, tbl[3].msk, tbl[3].exp, -1, -1, 8);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", 32'({busy_s[0], done_s[0], a_s[0], b_s[0]}), 32'd0);
        run("post_rst", 0, 1, 2, tbl[0].msk, tbl[0].exp, -1, -1, -1);

        for (int r = 0; r < 10; r++) begin
            int idx = (r % 3 == 2) ? 1 : 0;
            int lp  = (idx == 1) ? 3 : 1;
            for (int v = 0; v < 4; v++)
                rm[v] = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
            run($sformatf("rand%0d", r), idx, lp, 2, rm, model(rm, 4 * lp), -1, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
